// File: rtl/operand_bus_arbiter.sv
// operand_bus_arbiter: round-robin arbiter with locked bursts that shares one VPU lane operand path between requesters A and B
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   a_valid/a_data/a_lock/a_ready  requester A (source 0) beat, lock request, accept
//   b_valid/b_data/b_lock/b_ready  requester B (source 1) beat, lock request, accept
//   out_valid/out_data/out_sel     registered winning beat and its source (0 = A, 1 = B)
//   out_ready                      consumer accepts the output beat
//   busy                           ownership held or output register occupied
module operand_bus_arbiter #(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_lock,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_lock,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sel,
    input  logic              out_ready,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_sel_q, last_sel_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_sel_q, out_sel_d;
    logic              gnt_a, gnt_b, ld, xfer, xsel, xlock, own_lock, can_lock;
    logic [CNT_W:0]    cnt_inc;
    // in IDLE a tie goes to the requester that did not win last time
    assign gnt_a    = (state_q == OWN_A) || (state_q == IDLE && a_valid && (!b_valid || last_sel_q));
    assign gnt_b    = (state_q == OWN_B) || (state_q == IDLE && b_valid && (!a_valid || !last_sel_q));
    assign ld       = !out_valid_q || out_ready;
    assign a_ready  = gnt_a && a_valid && ld;
    assign b_ready  = gnt_b && b_valid && ld;
    assign xfer     = a_ready || b_ready;
    assign xsel     = b_ready;
    assign xlock    = xsel ? b_lock : a_lock;
    assign own_lock = (state_q == OWN_B) ? b_lock : a_lock;
    // one extra bit so the cap comparison can never wrap
    assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign can_lock = cnt_inc < (CNT_W+1)'(MAX_BURST);
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_sel_d  = last_sel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = xsel ? b_data : a_data;
            out_sel_d   = xsel;
            if (xlock && can_lock) begin
                state_d = xsel ? OWN_B : OWN_A;
                cnt_d   = cnt_inc[CNT_W-1:0];
            end else begin
                state_d    = IDLE;
                cnt_d      = '0;
                last_sel_d = xsel;
            end
        end else if (ld) begin
            // ownership is only released when the output stage is not stalled
            out_valid_d = 1'b0;
            if (state_q != IDLE && !own_lock) begin
                state_d    = IDLE;
                cnt_d      = '0;
                last_sel_d = (state_q == OWN_B);
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_sel_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_sel_q  <= last_sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign busy      = (state_q != IDLE) || out_valid_q;
endmodule

// File: tb/tb_operand_bus_arbiter.sv
// tb_operand_bus_arbiter: scenario tasks plus a scoreboard of accepted beats checked against the output stream
module tb_operand_bus_arbiter;
    logic        clk, rst;
    logic        a_valid, a_lock, a_ready, b_valid, b_lock, b_ready;
    logic [31:0] a_data, b_data, out_data;
    logic        out_valid, out_sel, out_ready, busy;
    logic [32:0] sb[$];
    logic [32:0] exp_beat;
    int          n_pass, n_total;

    operand_bus_arbiter #(.DATA_W(32), .MAX_BURST(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_lock(a_lock), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_lock(b_lock), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL scoreboard: unexpected beat sel=%0d data=%h, none required", out_sel, out_data);
                end else begin
                    exp_beat = sb.pop_front();
                    if ({out_sel, out_data} !== exp_beat)
                        $display("FAIL scoreboard: got sel=%0d data=%h, required sel=%0d data=%h",
                                 out_sel, out_data, exp_beat[32], exp_beat[31:0]);
                    else n_pass++;
                end
            end
            if (a_ready) sb.push_back({1'b0, a_data});
            if (b_ready) sb.push_back({1'b1, b_data});
        end
    end

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; a_lock = 0; b_lock = 0;
    endtask

    task automatic drain();
        idle_inputs();
        out_ready = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        a_data = 0; b_data = 0; out_ready = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else n_pass++;
        n_total++; if (out_sel !== 1'b0) $display("FAIL reset_out_sel: got %b required 0", out_sel); else n_pass++;
        n_total++; if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h required 0", out_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
        n_total++; if ({a_ready, b_ready} !== 2'b00) $display("FAIL reset_ready: got %b required 00", {a_ready, b_ready}); else n_pass++;
        rst = 0;
    endtask

    task automatic test_alternate();
        a_valid = 1; b_valid = 1; out_ready = 1;
        for (int n = 0; n < 8; n++) begin
            a_data = 32'hA0 + n; b_data = 32'hB0 + n;
            #1;
            n_total++;
            if (a_ready !== (n % 2 == 0) || b_ready !== (n % 2 == 1))
                $display("FAIL alt_ready[%0d]: got a=%b b=%b required a=%b", n, a_ready, b_ready, n % 2 == 0);
            else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if (out_valid !== 1'b1 || out_sel !== 1'(n % 2) || out_data !== ((n % 2 == 0) ? 32'hA0 + n : 32'hB0 + n))
                $display("FAIL alt_out[%0d]: got v=%b sel=%b data=%h required v=1 sel=%0d", n, out_valid, out_sel, out_data, n % 2);
            else n_pass++;
        end
        drain();
        n_total++;
        if (out_valid !== 1'b0 || out_data !== 32'hB7 || out_sel !== 1'b1)
            $display("FAIL alt_drain: got v=%b sel=%b data=%h required v=0 sel=1 data=b7", out_valid, out_sel, out_data);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        idle_inputs();
        b_valid = 1; b_data = 32'h1234_5678; out_ready = 0;
        #1;
        n_total++; if (b_ready !== 1'b1) $display("FAIL bp_first_ready: got %b required 1", b_ready); else n_pass++;
        @(posedge clk); #1;
        b_data = 32'h9ABC_DEF0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (b_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h1234_5678)
                $display("FAIL bp_stall[%0d]: got ready=%b v=%b data=%h required ready=0 v=1 data=12345678", i, b_ready, out_valid, out_data);
            else n_pass++;
            @(posedge clk); #1;
        end
        out_ready = 1;
        #1;
        n_total++; if (b_ready !== 1'b1) $display("FAIL bp_refill_ready: got %b required 1", b_ready); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (out_data !== 32'h9ABC_DEF0) $display("FAIL bp_refill_data: got %h required 9abcdef0", out_data); else n_pass++;
        b_valid = 0;
        #1;
        n_total++; if (b_ready !== 1'b0) $display("FAIL bp_no_valid: got %b required 0", b_ready); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_lock_burst();
        a_valid = 1; b_valid = 1; a_lock = 1; b_lock = 0; out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            a_data = 32'hC0 + i; b_data = 32'hD0 + i;
            @(posedge clk); #1;
            n_total++;
            if (out_sel !== (i == 4))
                $display("FAIL lock_sel[%0d]: got %b required %b", i, out_sel, i == 4);
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_starve_release();
        idle_inputs();
        a_valid = 1; a_lock = 1; a_data = 32'hE0; out_ready = 1;
        @(posedge clk); #1;
        a_valid = 0; b_valid = 1; b_data = 32'hF0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_total++; if (b_ready !== 1'b0) $display("FAIL starve_ready[%0d]: got %b required 0", i, b_ready); else n_pass++;
            @(posedge clk); #1;
        end
        n_total++; if (busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL starve_busy: got busy=%b v=%b required busy=1 v=0", busy, out_valid); else n_pass++;
        a_lock = 0;
        #1;
        n_total++; if (b_ready !== 1'b0) $display("FAIL release_cycle_ready: got %b required 0", b_ready); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (b_ready !== 1'b1) $display("FAIL release_grant_b: got %b required 1", b_ready); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (out_sel !== 1'b1 || out_data !== 32'hF0) $display("FAIL release_out: got sel=%b data=%h required sel=1 data=f0", out_sel, out_data); else n_pass++;
        drain();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        b_valid = 1; b_lock = 1; b_data = 32'h55; out_ready = 0;
        @(posedge clk); #1;
        n_total++; if (out_valid !== 1'b1 || busy !== 1'b1) $display("FAIL ar_setup: got v=%b busy=%b required 1 1", out_valid, busy); else n_pass++;
        #2 rst = 1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_sel !== 1'b0 || busy !== 1'b0)
            $display("FAIL ar_immediate: got v=%b sel=%b busy=%b required 0 0 0", out_valid, out_sel, busy);
        else n_pass++;
        idle_inputs();
        out_ready = 1;
        sb.delete();
        @(posedge clk); #1;
        rst = 0;
        a_valid = 1; b_valid = 1; a_data = 32'h11; b_data = 32'h22;
        #1;
        n_total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) $display("FAIL ar_tie_ready: got a=%b b=%b required a=1 b=0", a_ready, b_ready); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (out_sel !== 1'b0 || out_data !== 32'h11) $display("FAIL ar_tie_out: got sel=%b data=%h required sel=0 data=11", out_sel, out_data); else n_pass++;
        drain();
    endtask

    task automatic test_toggle_ready();
        int ka, kb;
        ka = 0; kb = 0;
        a_valid = 1; b_valid = 1; a_lock = 0; b_lock = 0;
        for (int i = 0; i < 12; i++) begin
            a_data = 32'hA0 + ka; b_data = 32'hB0 + kb;
            out_ready = (i % 2 == 0);
            #1;
            if (a_ready) ka++;
            if (b_ready) kb++;
            @(posedge clk); #1;
        end
        drain();
        n_total++; if (sb.size() != 0) $display("FAIL toggle_leftover: got %0d queued required 0", sb.size()); else n_pass++;
        n_total++; if (ka != 3 || kb != 3) $display("FAIL toggle_counts: got a=%0d b=%0d required 3 3", ka, kb); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL toggle_end_valid: got %b required 0", out_valid); else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        test_reset();
        test_alternate();
        test_backpressure();
        test_lock_burst();
        test_starve_release();
        test_async_reset();
        test_toggle_ready();
        n_total++; if (sb.size() != 0) $display("FAIL final_queue: got %0d queued required 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
